keycode_action_decoder: RTL

- Receiving end of the USB keycode GPIO path. Takes the two 32-bit keycode words written by the MicroBlaze and turns them into per-player action flags for the sprite engine.
- Synchronises and stability-filters the words, then scans the six HID keycode slots once per frame. Publishes held, press-edge and latched-jump outputs, all aligned to frame boundaries.
- Sits between the bd_mario_wrapper GPIO outputs and the game engine, in the 25 MHz pixel domain.

---
 rtl/keycode_action_decoder_pkg.sv | 69 ++++++
 rtl/keycode_action_decoder_if.sv | 36 +++
 rtl/keycode_action_decoder_sync_filter.sv | 61 ++++++
 rtl/keycode_action_decoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/keycode_action_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mario_input_pkg: HID usage codes, action bit indices and scan FSM states |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mario_input_pkg;

  localparam logic [7:0] P1_LEFT      = 8'h04;
  localparam logic [7:0] P1_RIGHT     = 8'h07;
  localparam logic [7:0] P1_JUMP      = 8'h1A;
  localparam logic [7:0] P1_DOWN      = 8'h16;
  localparam logic [7:0] P2_LEFT      = 8'h50;
  localparam logic [7:0] P2_RIGHT     = 8'h4F;
  localparam logic [7:0] P2_JUMP      = 8'h52;
  localparam logic [7:0] P2_DOWN      = 8'h51;
  localparam logic [7:0] HID_EMPTY    = 8'h00;
  localparam logic [7:0] HID_ROLLOVER = 8'h01;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;
  localparam int JUMP  = 2;
  localparam int DOWN  = 3;

  localparam logic [2:0] LAST_SLOT = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_e;

  function automatic logic [3:0] decode_p1(input logic [7:0] code);
    logic [3:0] bits;
    bits = 4'b0000;
    case (code)
      P1_LEFT:  bits[LEFT]  = 1'b1;
      P1_RIGHT: bits[RIGHT] = 1'b1;
      P1_JUMP:  bits[JUMP]  = 1'b1;
      P1_DOWN:  bits[DOWN]  = 1'b1;
      default:  bits = 4'b0000;
    endcase
    return bits;
  endfunction

  function automatic logic [3:0] decode_p2(input logic [7:0] code);
    logic [3:0] bits;
    bits = 4'b0000;
    case (code)
      P2_LEFT:  bits[LEFT]  = 1'b1;
      P2_RIGHT: bits[RIGHT] = 1'b1;
      P2_JUMP:  bits[JUMP]  = 1'b1;
      P2_DOWN:  bits[DOWN]  = 1'b1;
      default:  bits = 4'b0000;
    endcase
    return bits;
  endfunction

  function automatic logic [3:0] cancel_opposing(input logic [3:0] acts);
    logic [3:0] res;
    res = acts;
    if (acts[LEFT] && acts[RIGHT]) begin
      res[LEFT]  = 1'b0;
      res[RIGHT] = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keycode_action_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keycode_action_decoder_if: GPIO keycode words in, per-player actions out |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface keycode_action_decoder_if;

  logic [31:0] keycode;
  logic [31:0] keycode2;
  logic        frame_tick;
  logic        jump_ack_p1;
  logic        jump_ack_p2;
  logic [3:0]  held_p1;
  logic [3:0]  held_p2;
  logic [3:0]  press_p1;
  logic [3:0]  press_p2;
  logic        jump_req_p1;
  logic        jump_req_p2;
  logic        rollover;
  logic        busy;

  // Driving side: CPU GPIO and game engine acknowledges.
  modport master (
    output keycode, keycode2, frame_tick, jump_ack_p1, jump_ack_p2,
    input  held_p1, held_p2, press_p1, press_p2,
    input  jump_req_p1, jump_req_p2, rollover, busy
  );

  modport slave (
    input  keycode, keycode2, frame_tick, jump_ack_p1, jump_ack_p2,
    output held_p1, held_p2, press_p1, press_p2,
    output jump_req_p1, jump_req_p2, rollover, busy
  );

endinterface
`default_nettype wire

// File: rtl/keycode_action_decoder_sync_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keycode_sync_filter: synchroniser, stability counter, 64-bit snapshot    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module keycode_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic [63:0] din,
  output logic      [63:0] snapshot
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][63:0] sync_q, sync_d;
  logic [63:0] sync_out;
  logic [63:0] prev_q, prev_d;
  logic [63:0] snap_q, snap_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Loading on the next count (not the registered one) keeps the first
  // changed sample out of the snapshot while the counter is still saturated.
  always_comb begin
    prev_d = sync_out;
    cnt_d  = 4'd0;
    if (sync_out == prev_q) begin
      cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 4'd1;
    end
    snap_d = (cnt_d == STABLE_MAX) ? sync_out : snap_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= 4'd0;
      snap_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign snapshot = snap_q;

endmodule
`default_nettype wire

// File: rtl/keycode_action_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keycode_action_decoder: frame-aligned HID slot scan into player actions  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module keycode_action_decoder
  import mario_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 4,
  parameter int CANCEL_OPPOSING = 1
) (
  input wire logic                 clk,
  input wire logic                 reset_n,
  keycode_action_decoder_if.slave  bus
);

  logic [63:0] snap;
  logic [15:0] unused_hi;

  keycode_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      ({bus.keycode2, bus.keycode}),
    .snapshot (snap)
  );

  assign unused_hi = snap[63:48];

  scan_state_e state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [3:0]  acc_p1_q, acc_p1_d;
  logic [3:0]  acc_p2_q, acc_p2_d;
  logic        err_q, err_d;
  logic        commit_q, commit_d;
  logic [7:0]  slot_byte;

  always_comb begin
    slot_byte = 8'h00;
    case (slot_q)
      3'd0:    slot_byte = snap[7:0];
      3'd1:    slot_byte = snap[15:8];
      3'd2:    slot_byte = snap[23:16];
      3'd3:    slot_byte = snap[31:24];
      3'd4:    slot_byte = snap[39:32];
      3'd5:    slot_byte = snap[47:40];
      default: slot_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    acc_p1_d = acc_p1_q;
    acc_p2_d = acc_p2_q;
    err_d    = err_q;
    commit_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick) begin
          acc_p1_d = 4'b0000;
          acc_p2_d = 4'b0000;
          err_d    = 1'b0;
          slot_d   = 3'd0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_p1_d = acc_p1_q | decode_p1(slot_byte);
        acc_p2_d = acc_p2_q | decode_p2(slot_byte);
        if (slot_byte == HID_ROLLOVER) begin
          err_d = 1'b1;
        end
        if (slot_q == LAST_SLOT) begin
          state_d = ST_COMMIT;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      ST_COMMIT: begin
        commit_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      slot_q   <= 3'd0;
      acc_p1_q <= 4'b0000;
      acc_p2_q <= 4'b0000;
      err_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      acc_p1_q <= acc_p1_d;
      acc_p2_q <= acc_p2_d;
      err_q    <= err_d;
      commit_q <= commit_d;
    end
  end

  logic [3:0] held_p1_q, held_p1_d, held_p2_q, held_p2_d;
  logic [3:0] press_p1_q, press_p1_d, press_p2_q, press_p2_d;
  logic       jump_req_p1_q, jump_req_p1_d, jump_req_p2_q, jump_req_p2_d;
  logic       rollover_q, rollover_d;
  logic [3:0] new_p1, new_p2;

  always_comb begin
    new_p1 = (CANCEL_OPPOSING != 0) ? cancel_opposing(acc_p1_q) : acc_p1_q;
    new_p2 = (CANCEL_OPPOSING != 0) ? cancel_opposing(acc_p2_q) : acc_p2_q;
  end

  // acc/err are still intact here: a new frame can only clear them on this
  // same edge, so the published frame always reflects the finished scan.
  always_comb begin
    held_p1_d  = held_p1_q;
    held_p2_d  = held_p2_q;
    press_p1_d = 4'b0000;
    press_p2_d = 4'b0000;
    rollover_d = rollover_q;
    if (commit_q) begin
      if (err_q) begin
        rollover_d = 1'b1;
      end else begin
        held_p1_d  = new_p1;
        held_p2_d  = new_p2;
        press_p1_d = new_p1 & ~held_p1_q;
        press_p2_d = new_p2 & ~held_p2_q;
        rollover_d = 1'b0;
      end
    end

    jump_req_p1_d = jump_req_p1_q;
    if (press_p1_d[JUMP]) begin
      jump_req_p1_d = 1'b1;
    end else if (bus.jump_ack_p1) begin
      jump_req_p1_d = 1'b0;
    end

    jump_req_p2_d = jump_req_p2_q;
    if (press_p2_d[JUMP]) begin
      jump_req_p2_d = 1'b1;
    end else if (bus.jump_ack_p2) begin
      jump_req_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_p1_q     <= 4'b0000;
      held_p2_q     <= 4'b0000;
      press_p1_q    <= 4'b0000;
      press_p2_q    <= 4'b0000;
      jump_req_p1_q <= 1'b0;
      jump_req_p2_q <= 1'b0;
      rollover_q    <= 1'b0;
    end else begin
      held_p1_q     <= held_p1_d;
      held_p2_q     <= held_p2_d;
      press_p1_q    <= press_p1_d;
      press_p2_q    <= press_p2_d;
      jump_req_p1_q <= jump_req_p1_d;
      jump_req_p2_q <= jump_req_p2_d;
      rollover_q    <= rollover_d;
    end
  end

  assign bus.held_p1     = held_p1_q;
  assign bus.held_p2     = held_p2_q;
  assign bus.press_p1    = press_p1_q;
  assign bus.press_p2    = press_p2_q;
  assign bus.jump_req_p1 = jump_req_p1_q;
  assign bus.jump_req_p2 = jump_req_p2_q;
  assign bus.rollover    = rollover_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
